// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, FSM states, ALU op encodings and control bundle for the multicycle MIPS controller
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADDR = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_RWB     = 4'd8,
        S_BEQ     = 4'd9,
        S_JMP     = 4'd10,
        S_ADDIEX  = 4'd11,
        S_ADDIWB  = 4'd12
    } state_t;
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic       pc_en;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
        logic       retire;
        logic       illegal;
    } ctrl_t;
    function automatic state_t decode_next(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW: return S_MEMADDR;
            OP_RTYPE:     return S_EXEC;
            OP_BEQ:       return S_BEQ;
            OP_J:         return S_JMP;
            OP_ADDI:      return S_ADDIEX;
            default:      return S_FETCH;
        endcase
    endfunction
endpackage

// File: rtl/mips_ctrl_outdec.sv
// mips_ctrl_outdec: combinational state-to-control decoder with mem_ready/zero gating
module mips_ctrl_outdec
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read = 1'b1;
                ctrl.ir_write = mem_ready;
                ctrl.pc_en    = mem_ready;
            end
            S_DECODE:  ctrl.illegal = decode_next(opcode) == S_FETCH;
            S_MEMADDR: ctrl.alu_src = 1'b1;
            S_MEMRD:   ctrl.mem_read = 1'b1;
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.retire    = mem_ready;
            end
            S_EXEC: ctrl.alu_op = ALU_FUNCT;
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_op = ALU_SUB;
                ctrl.branch = 1'b1;
                ctrl.pc_en  = zero;
                ctrl.retire = 1'b1;
            end
            S_JMP: begin
                ctrl.jump   = 1'b1;
                ctrl.pc_en  = 1'b1;
                ctrl.retire = 1'b1;
            end
            S_ADDIEX: ctrl.alu_src = 1'b1;
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.retire    = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS control FSM with retired-instruction counter
module mips_multicycle_control
    import mips_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        reg_dst,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic        branch,
    output logic        jump,
    output logic        pc_en,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  alu_op,
    output logic        retire,
    output logic        illegal,
    output logic [31:0] instr_count,
    output logic [3:0]  state
);
    state_t      state_q, state_d;
    logic [31:0] count_q, count_d;
    ctrl_t       ctrl;
    mips_ctrl_outdec u_outdec (
        .state     (state_q),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:    state_d = S_FETCH;
            S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:  state_d = decode_next(opcode);
            S_MEMADDR: state_d = opcode == OP_LW ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:    state_d = S_RWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_MEMWB, S_RWB, S_BEQ, S_JMP, S_ADDIWB: state_d = S_FETCH;
            default:   state_d = S_IDLE;
        endcase
        count_d = count_q + 32'(ctrl.retire);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end
    assign {reg_dst, alu_src, mem_to_reg, branch, jump, pc_en, ir_write,
            reg_write, mem_read, mem_write, alu_op, retire, illegal} = ctrl;
    assign instr_count = count_q;
    assign state       = state_q;
endmodule
